// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared constants, FSM encoding and queue entry type for the BTB update path
package btb_pkg;

  localparam int NUM_ENTRIES        = 8;
  localparam int INDEX_W            = 3;
  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int XLEN               = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [XLEN-1:0]    tag;
    logic [XLEN-1:0]    target;
  } upd_t;

endpackage

// File: rtl/btb_update_ctrl_if.sv
// rtl/btb_update_ctrl_if.sv - update request handshakes and BTB write port
interface btb_update_ctrl_if;
  import btb_pkg::*;

  logic            br_valid;
  logic            br_ready;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] br_target;

  logic            jmp_valid;
  logic            jmp_ready;
  logic [XLEN-1:0] jmp_pc;
  logic [XLEN-1:0] jmp_target;

  logic               wr_en;
  logic [INDEX_W-1:0] wr_index;
  logic [XLEN-1:0]    wr_tag;
  logic [XLEN-1:0]    wr_target;
  logic               wr_vbit;

  modport master (
    output br_valid, br_pc, br_target, jmp_valid, jmp_pc, jmp_target,
    input  br_ready, jmp_ready, wr_en, wr_index, wr_tag, wr_target, wr_vbit
  );

  modport slave (
    input  br_valid, br_pc, br_target, jmp_valid, jmp_pc, jmp_target,
    output br_ready, jmp_ready, wr_en, wr_index, wr_tag, wr_target, wr_vbit
  );

endinterface

// File: rtl/btb_update_fifo.sv
// rtl/btb_update_fifo.sv - dual-push, single-pop update queue; push_a lands ahead of push_b
module btb_update_fifo
  import btb_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push_a,
  input  upd_t          data_a,
  input  logic          push_b,
  input  upd_t          data_b,
  input  logic          pop,
  output upd_t          head,
  output logic [CW-1:0] count
);

  upd_t          mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr_b;
  logic [PW-1:0] wr_ptr_nxt;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_comb begin
    wr_ptr_b   = push_a ? ptr_inc(wr_ptr) : wr_ptr;
    wr_ptr_nxt = push_b ? ptr_inc(wr_ptr_b) : wr_ptr_b;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CW'(push_a) + CW'(push_b) - CW'(do_pop);
    end
  end

  // Storage needs no reset: an empty count makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push_a) begin
      mem[wr_ptr] <= data_a;
    end
    if (push_b) begin
      mem[wr_ptr_b] <= data_b;
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - queues branch/jump BTB updates and walks all entries invalid on flush
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int LOWER      = 5,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic flush_req,
  output logic flush_busy,
  output logic flush_done,
  btb_update_ctrl_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t             state;
  logic [INDEX_W-1:0] walk_idx;
  logic [CW-1:0]      count;
  upd_t               head;
  upd_t               jmp_entry;
  upd_t               br_entry;
  logic               idle_go;
  logic               jmp_push;
  logic               br_push;
  logic               pop;
  logic               flush_start;

  // A flush request closes the request side in the same cycle it is seen.
  assign idle_go     = en && (state == ST_IDLE) && !flush_req;
  assign flush_start = en && (state == ST_IDLE) && flush_req;

  assign bus.jmp_ready = idle_go && (count < CW'(FIFO_DEPTH));
  assign bus.br_ready  = idle_go &&
                         ((count < CW'(FIFO_DEPTH - 1)) ||
                          ((count == CW'(FIFO_DEPTH - 1)) && !bus.jmp_valid));

  assign jmp_push = bus.jmp_valid && bus.jmp_ready;
  assign br_push  = bus.br_valid && bus.br_ready;
  assign pop      = idle_go && (count != '0);

  assign flush_busy = (state != ST_IDLE);
  assign flush_done = (state == ST_DONE);

  always_comb begin
    jmp_entry = '{index: INDEX_W'(bus.jmp_pc[LOWER-1:2]), tag: bus.jmp_pc, target: bus.jmp_target};
    br_entry  = '{index: INDEX_W'(bus.br_pc[LOWER-1:2]),  tag: bus.br_pc,  target: bus.br_target};
  end

  btb_update_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush_start),
    .push_a (jmp_push),
    .data_a (jmp_entry),
    .push_b (br_push),
    .data_b (br_entry),
    .pop    (pop),
    .head   (head),
    .count  (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      walk_idx      <= '0;
      bus.wr_en     <= 1'b0;
      bus.wr_vbit   <= 1'b0;
      bus.wr_index  <= '0;
      bus.wr_tag    <= '0;
      bus.wr_target <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      if (en) begin
        unique case (state)
          ST_IDLE: begin
            if (flush_req) begin
              state    <= ST_FLUSH;
              walk_idx <= '0;
            end else if (pop) begin
              bus.wr_en     <= 1'b1;
              bus.wr_vbit   <= 1'b1;
              bus.wr_index  <= head.index;
              bus.wr_tag    <= head.tag;
              bus.wr_target <= head.target;
            end
          end
          ST_FLUSH: begin
            bus.wr_en     <= 1'b1;
            bus.wr_vbit   <= 1'b0;
            bus.wr_index  <= walk_idx;
            bus.wr_tag    <= '0;
            bus.wr_target <= '0;
            walk_idx      <= walk_idx + INDEX_W'(1);
            if (walk_idx == INDEX_W'(NUM_ENTRIES - 1)) begin
              state <= ST_DONE;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb/tb_btb_update_ctrl.sv - directed self-checking bench for btb_update_ctrl
module tb_btb_update_ctrl;

  logic clk;
  logic rst;
  logic en;
  logic flush_req;
  logic flush_busy;
  logic flush_done;

  int n_tests;
  int n_fail;

  btb_update_ctrl_if bus ();

  btb_update_ctrl #(.LOWER(5), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .flush_done (flush_done),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic [2:0] idx, input logic [63:0] tg,
                          input logic [63:0] tgt, input logic vb);
    check({tag, "_en"},     64'(bus.wr_en),    64'd1);
    check({tag, "_index"},  64'(bus.wr_index), 64'(idx));
    check({tag, "_tag"},    bus.wr_tag,        tg);
    check({tag, "_target"}, bus.wr_target,     tgt);
    check({tag, "_vbit"},   64'(bus.wr_vbit),  64'(vb));
  endtask

  task automatic set_br(input logic v, input logic [63:0] pc, input logic [63:0] tgt);
    bus.br_valid  = v;
    bus.br_pc     = pc;
    bus.br_target = tgt;
  endtask

  task automatic set_jmp(input logic v, input logic [63:0] pc, input logic [63:0] tgt);
    bus.jmp_valid  = v;
    bus.jmp_pc     = pc;
    bus.jmp_target = tgt;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    en        = 1'b1;
    flush_req = 1'b0;
    set_br(1'b0, 64'h0, 64'h0);
    set_jmp(1'b0, 64'h0, 64'h0);
    tick();
    tick();

    // reset state
    check("rst_wr_en",      64'(bus.wr_en),     64'd0);
    check("rst_wr_index",   64'(bus.wr_index),  64'd0);
    check("rst_wr_tag",     bus.wr_tag,         64'd0);
    check("rst_wr_target",  bus.wr_target,      64'd0);
    check("rst_wr_vbit",    64'(bus.wr_vbit),   64'd0);
    check("rst_busy",       64'(flush_busy),    64'd0);
    check("rst_done",       64'(flush_done),    64'd0);
    check("rst_br_ready",   64'(bus.br_ready),  64'd1);
    check("rst_jmp_ready",  64'(bus.jmp_ready), 64'd1);
    rst = 1'b0;

    // single branch: write appears two edges after acceptance
    set_br(1'b1, 64'h1008, 64'h2000);
    tick();
    check("br_lat1_wr_en", 64'(bus.wr_en), 64'd0);
    set_br(1'b0, 64'h0, 64'h0);
    tick();
    check_wr("br_single", 3'd2, 64'h1008, 64'h2000, 1'b1);
    tick();
    check("br_after_wr_en", 64'(bus.wr_en), 64'd0);
    check("br_after_hold_index", 64'(bus.wr_index), 64'd2);

    // jump and branch together: jump written first
    set_jmp(1'b1, 64'h100C, 64'h3000);
    set_br(1'b1, 64'h1004, 64'h4000);
    #1;
    check("dual_jmp_ready", 64'(bus.jmp_ready), 64'd1);
    check("dual_br_ready",  64'(bus.br_ready),  64'd1);
    tick();
    set_jmp(1'b0, 64'h0, 64'h0);
    set_br(1'b0, 64'h0, 64'h0);
    check("dual_lat1_wr_en", 64'(bus.wr_en), 64'd0);
    tick();
    check_wr("dual_first", 3'd3, 64'h100C, 64'h3000, 1'b1);
    tick();
    check_wr("dual_second", 3'd1, 64'h1004, 64'h4000, 1'b1);
    tick();
    check("dual_end_wr_en", 64'(bus.wr_en), 64'd0);

    // fill to three entries; at count 3 a jump blocks the branch
    set_jmp(1'b1, 64'h2000, 64'hA1);
    set_br(1'b1, 64'h2004, 64'hB1);
    tick();
    set_jmp(1'b1, 64'h2008, 64'hA2);
    set_br(1'b1, 64'h200C, 64'hB2);
    #1;
    check("fill_c2_jmp_ready", 64'(bus.jmp_ready), 64'd1);
    check("fill_c2_br_ready",  64'(bus.br_ready),  64'd1);
    tick();
    check_wr("fill_w0", 3'd0, 64'h2000, 64'hA1, 1'b1);
    set_jmp(1'b1, 64'h2010, 64'hA3);
    set_br(1'b1, 64'h2014, 64'hB3);
    #1;
    check("fill_c3_jmp_ready", 64'(bus.jmp_ready), 64'd1);
    check("fill_c3_br_ready",  64'(bus.br_ready),  64'd0);
    bus.jmp_valid = 1'b0;
    #1;
    check("fill_c3_br_alone_ready", 64'(bus.br_ready), 64'd1);
    bus.jmp_valid = 1'b1;
    tick();
    set_jmp(1'b0, 64'h0, 64'h0);
    set_br(1'b0, 64'h0, 64'h0);
    check_wr("fill_w1", 3'd1, 64'h2004, 64'hB1, 1'b1);
    tick();
    check_wr("fill_w2", 3'd2, 64'h2008, 64'hA2, 1'b1);
    tick();
    check_wr("fill_w3", 3'd3, 64'h200C, 64'hB2, 1'b1);
    tick();
    check_wr("fill_w4", 3'd4, 64'h2010, 64'hA3, 1'b1);
    tick();
    check("fill_drained_wr_en", 64'(bus.wr_en), 64'd0);

    en = 1'b0;
    #1;
    check("en0_jmp_ready", 64'(bus.jmp_ready), 64'd0);
    check("en0_br_ready",  64'(bus.br_ready),  64'd0);
    en = 1'b1;

    // flush with two queued entries
    set_jmp(1'b1, 64'h3000, 64'hC1);
    set_br(1'b1, 64'h3004, 64'hC2);
    tick();
    set_jmp(1'b0, 64'h0, 64'h0);
    set_br(1'b1, 64'h3008, 64'hC3);
    flush_req = 1'b1;
    #1;
    check("flush_beats_br_ready",  64'(bus.br_ready),  64'd0);
    check("flush_beats_jmp_ready", 64'(bus.jmp_ready), 64'd0);
    tick();
    flush_req = 1'b0;
    set_br(1'b0, 64'h0, 64'h0);
    check("flush_enter_wr_en", 64'(bus.wr_en),  64'd0);
    check("flush_enter_busy",  64'(flush_busy), 64'd1);
    check("flush_enter_done",  64'(flush_done), 64'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_wr($sformatf("flush_walk%0d", i), 3'(i), 64'd0, 64'd0, 1'b0);
      check($sformatf("flush_walk%0d_done", i), 64'(flush_done), (i == 7) ? 64'd1 : 64'd0);
      check($sformatf("flush_walk%0d_busy", i), 64'(flush_busy), 64'd1);
    end
    tick();
    check("flush_idle_done",      64'(flush_done),    64'd0);
    check("flush_idle_busy",      64'(flush_busy),    64'd0);
    check("flush_idle_wr_en",     64'(bus.wr_en),     64'd0);
    check("flush_idle_jmp_ready", 64'(bus.jmp_ready), 64'd1);
    check("flush_idle_br_ready",  64'(bus.br_ready),  64'd1);
    tick();
    check("flush_queue_dropped", 64'(bus.wr_en), 64'd0);

    // reset at the fourth walk step
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    tick();
    tick();
    check_wr("rstwalk_step2", 3'd2, 64'd0, 64'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstwalk_wr_en",     64'(bus.wr_en),     64'd0);
    check("rstwalk_wr_index",  64'(bus.wr_index),  64'd0);
    check("rstwalk_wr_tag",    bus.wr_tag,         64'd0);
    check("rstwalk_wr_target", bus.wr_target,      64'd0);
    check("rstwalk_wr_vbit",   64'(bus.wr_vbit),   64'd0);
    check("rstwalk_busy",      64'(flush_busy),    64'd0);
    check("rstwalk_done",      64'(flush_done),    64'd0);
    check("rstwalk_jmp_ready", 64'(bus.jmp_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rstwalk_quiet%0d", i), 64'(bus.wr_en), 64'd0);
    end

    // en low for three cycles mid-walk; flush_req outside IDLE is ignored
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    check_wr("pause_step0", 3'd0, 64'd0, 64'd0, 1'b0);
    tick();
    check_wr("pause_step1", 3'd1, 64'd0, 64'd0, 1'b0);
    en        = 1'b0;
    flush_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("pause_en0_%0d_wr_en", i), 64'(bus.wr_en),    64'd0);
      check($sformatf("pause_en0_%0d_busy", i),  64'(flush_busy),   64'd1);
      check($sformatf("pause_en0_%0d_index", i), 64'(bus.wr_index), 64'd1);
    end
    en = 1'b1;
    for (int i = 2; i < 8; i++) begin
      tick();
      flush_req = 1'b0;
      check_wr($sformatf("pause_step%0d", i), 3'(i), 64'd0, 64'd0, 1'b0);
    end
    check("pause_done", 64'(flush_done), 64'd1);
    tick();
    check("pause_idle_done",  64'(flush_done), 64'd0);
    check("pause_idle_busy",  64'(flush_busy), 64'd0);
    check("pause_idle_wr_en", 64'(bus.wr_en),  64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
